// File: rtl/cnn_layer_accel_awe_rowbuf_sched.sv
// cnn_layer_accel_awe_rowbuf_sched
//   Per-AWE read scheduler for the AWE row buffers. For each output row it waits
//   for a full kernel window (rows_ready), then walks cycle -> kernel -> col,
//   issuing one row-buffer read per beat with its tags, and releases the row to
//   the fill side when the row is finished.
//
// Ports
//   clk_core, rst            core clock, async active-low reset
//   job_start / _ack         job request (IDLE only) / 1-cycle accept pulse
//   *_cfg                    R, C, N, K, S latched on accept
//   rows_ready               row buffers hold the window for the next output row
//   row_release              1-cycle pulse after each finished row
//   stall, abort             freeze sequence / return to IDLE (abort wins)
//   rd_en, rd_col_addr       read strobe and column (col*S + cycle)
//   output_row/_col, cycle_counter, last_kernel   tags aligned with rd_en
//   busy, job_done           state != IDLE / 1-cycle normal-completion pulse
//   stall_cycles             RUN cycles with stall=1 (CNL_RBSCHED_PERF_CNT_EN only)
//
// Build option: define CNL_RBSCHED_PERF_CNT_EN to add the stall_cycles counter.
module cnn_layer_accel_awe_rowbuf_sched #(
    parameter int C_ROW_W = 10,
    parameter int C_COL_W = 10,
    parameter int C_KRN_W = 8,
    parameter int C_KSZ_W = 4,
    parameter int C_STR_W = 3
) (
    input  logic               clk_core,
    input  logic               rst,
    input  logic               job_start,
    output logic               job_start_ack,
    input  logic [C_ROW_W-1:0] num_output_rows_cfg,
    input  logic [C_COL_W-1:0] num_output_cols_cfg,
    input  logic [C_KRN_W-1:0] num_kernel_cfg,
    input  logic [C_KSZ_W-1:0] kernel_size_cfg,
    input  logic [C_STR_W-1:0] convolution_stride_cfg,
    input  logic               rows_ready,
    output logic               row_release,
    input  logic               stall,
    input  logic               abort,
    output logic               rd_en,
    output logic [C_COL_W-1:0] rd_col_addr,
    output logic [C_ROW_W-1:0] output_row,
    output logic [C_COL_W-1:0] output_col,
    output logic [C_KSZ_W-1:0] cycle_counter,
    output logic               last_kernel,
    output logic               busy,
    output logic               job_done
`ifdef CNL_RBSCHED_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int AW = C_COL_W + C_STR_W + C_KSZ_W;
    localparam logic [C_ROW_W-1:0] ROW_ONE = C_ROW_W'(1);
    localparam logic [C_COL_W-1:0] COL_ONE = C_COL_W'(1);
    localparam logic [C_KRN_W-1:0] KRN_ONE = C_KRN_W'(1);
    localparam logic [C_KSZ_W-1:0] KSZ_ONE = C_KSZ_W'(1);

    typedef enum logic [2:0] {IDLE, WAIT_ROWS, RUN, ROW_DONE, DONE} state_t;
    state_t state;

    logic [C_ROW_W-1:0] rows_r;
    logic [C_COL_W-1:0] cols_r;
    logic [C_KRN_W-1:0] krn_r;
    logic [C_KSZ_W-1:0] ksz_r;
    logic [C_STR_W-1:0] str_r;
    logic [C_KRN_W-1:0] kern;
    logic [AW-1:0]      addr_full;

    // Tags are the live counter registers, so they line up with rd_en by construction.
    assign rd_en       = (state == RUN) && !stall;
    assign busy        = (state != IDLE);
    assign last_kernel = rd_en && (kern == krn_r - KRN_ONE);
    assign addr_full   = AW'(output_col) * AW'(str_r) + AW'(cycle_counter);
    assign rd_col_addr = addr_full[C_COL_W-1:0];

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rows_r        <= '0;
            cols_r        <= '0;
            krn_r         <= '0;
            ksz_r         <= '0;
            str_r         <= '0;
            kern          <= '0;
            output_row    <= '0;
            output_col    <= '0;
            cycle_counter <= '0;
            job_start_ack <= 1'b0;
            row_release   <= 1'b0;
            job_done      <= 1'b0;
        end else begin
            job_start_ack <= 1'b0;
            row_release   <= 1'b0;
            job_done      <= 1'b0;
            if (state != IDLE && abort) begin
                state         <= IDLE;
                kern          <= '0;
                output_row    <= '0;
                output_col    <= '0;
                cycle_counter <= '0;
            end else begin
                case (state)
                    IDLE: if (job_start) begin
                        rows_r        <= num_output_rows_cfg;
                        cols_r        <= num_output_cols_cfg;
                        krn_r         <= num_kernel_cfg;
                        ksz_r         <= kernel_size_cfg;
                        str_r         <= convolution_stride_cfg;
                        job_start_ack <= 1'b1;
                        kern          <= '0;
                        output_row    <= '0;
                        output_col    <= '0;
                        cycle_counter <= '0;
                        // An empty job skips straight to completion.
                        if (num_output_rows_cfg == '0 || num_output_cols_cfg == '0 ||
                            num_kernel_cfg == '0 || kernel_size_cfg == '0)
                            state <= DONE;
                        else
                            state <= WAIT_ROWS;
                    end
                    WAIT_ROWS: if (rows_ready) state <= RUN;
                    RUN: if (!stall) begin
                        if (cycle_counter != ksz_r - KSZ_ONE) begin
                            cycle_counter <= cycle_counter + KSZ_ONE;
                        end else begin
                            cycle_counter <= '0;
                            if (kern != krn_r - KRN_ONE) begin
                                kern <= kern + KRN_ONE;
                            end else begin
                                kern <= '0;
                                // Column stays at C-1 on the final beat; ROW_DONE rewinds it.
                                if (output_col != cols_r - COL_ONE)
                                    output_col <= output_col + COL_ONE;
                                else
                                    state <= ROW_DONE;
                            end
                        end
                    end
                    ROW_DONE: begin
                        row_release <= 1'b1;
                        if (output_row == rows_r - ROW_ONE) begin
                            state <= DONE;
                        end else begin
                            output_row <= output_row + ROW_ONE;
                            output_col <= '0;
                            state      <= WAIT_ROWS;
                        end
                    end
                    DONE: begin
                        // job_done rises together with the return to IDLE, so busy is already low.
                        job_done <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CNL_RBSCHED_PERF_CNT_EN
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (state == IDLE && job_start)
            stall_cycles <= '0;
        else if (state == RUN && stall && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cnn_layer_accel_awe_rowbuf_sched.sv
// Directed bench for cnn_layer_accel_awe_rowbuf_sched: reset state, two beat
// patterns, stall freeze, empty job, rows_ready gating, mid-job reset.
module tb_cnn_layer_accel_awe_rowbuf_sched;

    logic        clk_core = 1'b0;
    logic        rst = 1'b0;
    logic        job_start = 1'b0;
    logic        job_start_ack;
    logic [9:0]  num_output_rows_cfg = '0;
    logic [9:0]  num_output_cols_cfg = '0;
    logic [7:0]  num_kernel_cfg = '0;
    logic [3:0]  kernel_size_cfg = '0;
    logic [2:0]  convolution_stride_cfg = '0;
    logic        rows_ready = 1'b0;
    logic        row_release;
    logic        stall = 1'b0;
    logic        abort = 1'b0;
    logic        rd_en;
    logic [9:0]  rd_col_addr;
    logic [9:0]  output_row;
    logic [9:0]  output_col;
    logic [3:0]  cycle_counter;
    logic        last_kernel;
    logic        busy;
    logic        job_done;
`ifdef CNL_RBSCHED_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    cnn_layer_accel_awe_rowbuf_sched dut (
        .clk_core(clk_core), .rst(rst),
        .job_start(job_start), .job_start_ack(job_start_ack),
        .num_output_rows_cfg(num_output_rows_cfg), .num_output_cols_cfg(num_output_cols_cfg),
        .num_kernel_cfg(num_kernel_cfg), .kernel_size_cfg(kernel_size_cfg),
        .convolution_stride_cfg(convolution_stride_cfg),
        .rows_ready(rows_ready), .row_release(row_release),
        .stall(stall), .abort(abort),
        .rd_en(rd_en), .rd_col_addr(rd_col_addr),
        .output_row(output_row), .output_col(output_col),
        .cycle_counter(cycle_counter), .last_kernel(last_kernel),
        .busy(busy), .job_done(job_done)
`ifdef CNL_RBSCHED_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk_core = ~clk_core;

    // Beat log, written only here; tests index from a base snapshot.
    int q_addr[$], q_row[$], q_col[$], q_cyc[$], q_lk[$];
    int n_rel = 0, n_done = 0;
    always @(negedge clk_core) begin
        if (rd_en) begin
            q_addr.push_back(int'(rd_col_addr));
            q_row.push_back(int'(output_row));
            q_col.push_back(int'(output_col));
            q_cyc.push_back(int'(cycle_counter));
            q_lk.push_back(int'(last_kernel));
        end
        if (row_release) n_rel++;
        if (job_done) n_done++;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic start_job(input int r, input int c, input int n, input int k, input int s,
                             input string tag);
        num_output_rows_cfg    = 10'(r);
        num_output_cols_cfg    = 10'(c);
        num_kernel_cfg         = 8'(n);
        kernel_size_cfg        = 4'(k);
        convolution_stride_cfg = 3'(s);
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        #1;
        chk(tag, job_start_ack, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (!busy) break;
        end
        chk(tag, (i < budget), 1);
        tick();   // let the monitor log the job_done cycle
    endtask

    // Expected beat stream for R=2,C=2,N=1,K=3,S=1.
    task automatic chk_t1(input string tag, input int base);
        int ea[12] = '{0,1,2,1,2,3, 0,1,2,1,2,3};
        int er[12] = '{0,0,0,0,0,0, 1,1,1,1,1,1};
        int ec[12] = '{0,0,0,1,1,1, 0,0,0,1,1,1};
        int ey[12] = '{0,1,2,0,1,2, 0,1,2,0,1,2};
        chk({tag, "_beats"}, q_addr.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < q_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), q_addr[base+i], ea[i]);
                chk($sformatf("%s_row%0d", tag, i), q_row[base+i], er[i]);
                chk($sformatf("%s_col%0d", tag, i), q_col[base+i], ec[i]);
                chk($sformatf("%s_cyc%0d", tag, i), q_cyc[base+i], ey[i]);
                chk($sformatf("%s_lk%0d", tag, i), q_lk[base+i], 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, r0, d0;
        bit ok;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_ack", job_start_ack, 0);
        chk("rst_addr", rd_col_addr, 0);
        chk("rst_row", output_row, 0);
        chk("rst_done", job_done, 0);
        rst = 1'b1;
        tick();

        // T1: basic two-row job
        rows_ready = 1'b1;
        b = q_addr.size(); r0 = n_rel; d0 = n_done;
        start_job(2, 2, 1, 3, 1, "t1_ack");
        chk("t1_busy", busy, 1);
        wait_idle(200, "t1_timeout");
        chk_t1("t1", b);
        chk("t1_release", n_rel - r0, 2);
        chk("t1_done", n_done - d0, 1);

        // T2: stride 2, two kernels
        begin
            int ea[12] = '{0,1,0,1, 2,3,2,3, 4,5,4,5};
            int el[12] = '{0,0,1,1, 0,0,1,1, 0,0,1,1};
            b = q_addr.size(); r0 = n_rel;
            start_job(1, 3, 2, 2, 2, "t2_ack");
            wait_idle(200, "t2_timeout");
            chk("t2_beats", q_addr.size() - b, 12);
            for (int i = 0; i < 12; i++) begin
                if (b + i < q_addr.size()) begin
                    chk($sformatf("t2_addr%0d", i), q_addr[b+i], ea[i]);
                    chk($sformatf("t2_lk%0d", i), q_lk[b+i], el[i]);
                end
            end
            chk("t2_release", n_rel - r0, 1);
        end

        // T3: stall for 5 cycles before beat 4
        b = q_addr.size(); d0 = n_done;
        start_job(2, 2, 1, 3, 1, "t3_ack");
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (q_addr.size() - b == 3) begin ok = 1; break; end
        end
        chk("t3_reach_beat3", ok, 1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_rd", rd_en, 0);
            chk("t3_stall_col", output_col, 1);
            chk("t3_stall_cyc", cycle_counter, 0);
            chk("t3_stall_addr", rd_col_addr, 1);
            chk("t3_stall_lk", last_kernel, 0);
            tick();
        end
        stall = 1'b0;
        wait_idle(200, "t3_timeout");
        chk_t1("t3", b);
        chk("t3_done", n_done - d0, 1);
`ifdef CNL_RBSCHED_PERF_CNT_EN
        chk("t3_stall_cycles", stall_cycles, 5);
`endif

        // T4: N=0 completes without reads
        b = q_addr.size(); r0 = n_rel; d0 = n_done;
        start_job(2, 2, 0, 3, 1, "t4_ack");
        chk("t4_busy_ack", busy, 1);
        chk("t4_no_done_yet", job_done, 0);
        tick(); #1;
        chk("t4_done_pulse", job_done, 1);
        chk("t4_busy_drop", busy, 0);
        chk("t4_ack_low", job_start_ack, 0);
        tick(); #1;
        chk("t4_done_low", job_done, 0);
        chk("t4_no_reads", q_addr.size() - b, 0);
        chk("t4_no_release", n_rel - r0, 0);
        chk("t4_done_cnt", n_done - d0, 1);

        // T5: rows_ready low 10 cycles before row 1
        b = q_addr.size(); r0 = n_rel;
        start_job(2, 2, 1, 3, 1, "t5_ack");
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (q_addr.size() - b == 6) begin ok = 1; break; end
        end
        chk("t5_row0_beats", ok, 1);
        rows_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_gated_rd", rd_en, 0);
            tick();
        end
        rows_ready = 1'b1;
        #1;
        chk("t5_ready_cycle_rd", rd_en, 0);
        chk("t5_ready_busy", busy, 1);
        tick(); #1;
        chk("t5_first_rd", rd_en, 1);
        chk("t5_first_row", output_row, 1);
        chk("t5_first_col", output_col, 0);
        chk("t5_first_cyc", cycle_counter, 0);
        wait_idle(200, "t5_timeout");
        chk("t5_beats", q_addr.size() - b, 12);
        chk("t5_release", n_rel - r0, 2);

        // T6: reset at beat 7, then a fresh job
        b = q_addr.size(); d0 = n_done;
        start_job(2, 2, 1, 3, 1, "t6_ack");
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (q_addr.size() - b == 6 && rd_en) begin ok = 1; break; end
        end
        chk("t6_reach_beat7", ok, 1);
        chk("t6_pre_row", output_row, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_rd", rd_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_row", output_row, 0);
        chk("t6_rst_col", output_col, 0);
        chk("t6_rst_cyc", cycle_counter, 0);
        chk("t6_rst_addr", rd_col_addr, 0);
        chk("t6_rst_lk", last_kernel, 0);
        chk("t6_rst_rel", row_release, 0);
        tick(); tick();
        chk("t6_rst_hold_busy", busy, 0);
        rst = 1'b1;
        tick();
        chk("t6_no_done", n_done - d0, 0);
        b = q_addr.size();
        start_job(2, 2, 1, 3, 1, "t6_ack2");
        wait_idle(200, "t6_timeout");
        chk_t1("t6", b);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
